// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ cores.
// One word access in flight at a time: select (IDLE) -> memory cycle (ACCESS) -> done pulse (DONE).
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | no transaction in flight; pick next requester after r_last
//   S_ACCESS | memory pins driven from the latched request; read data captured
//   S_DONE   | done pulse to the served core; rotate priority past it
module dmem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         done,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REQ-1:0]         stall,
  output logic [IDX_W-1:0]           grant_id,
  output logic                       busy,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_last;
  logic               r_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [NUM_REQ-1:0] r_done;
  logic [DATA_W-1:0]  r_rdata;

  logic               w_any;
  logic [IDX_W-1:0]   w_sel;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [NUM_REQ-1:0] w_done_set;

  // Each requester gets its rotated distance from r_last+1; the nearest active one wins.
  always_comb begin
    int best;
    int d;
    best        = NUM_REQ;
    d           = 0;
    w_any       = 1'b0;
    w_sel       = '0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i > int'(r_last)) d = i - int'(r_last) - 1;
      else                  d = i + NUM_REQ - int'(r_last) - 1;
      if (req[i] && (d < best)) begin
        best        = d;
        w_any       = 1'b1;
        w_sel       = IDX_W'(i);
        w_sel_we    = we[i];
        w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_done_set = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx       <= w_sel;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!r_we) r_rdata <= mem_rdata;
          r_done  <= w_done_set;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_last  <= r_idx;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address/data registers double as the memory pins so they hold between accesses.
  assign mem_we    = (r_state == S_ACCESS) & r_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign grant_id  = r_idx;
  assign busy      = (r_state != S_IDLE);
  assign stall     = req & ~r_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model with
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_dmem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req, we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      done, stall;
  logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
  logic [IW-1:0]     grant_id;
  logic              busy, mem_we;
  logic [AW-1:0]     mem_addr;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .stall(stall), .grant_id(grant_id), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Memory attached to the DUT: synchronous write, combinational read.
  bit [31:0] tb_mem [256];
  bit        tb_wr  [256];
  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr[7:0]] <= mem_wdata;
      tb_wr[mem_addr[7:0]]  <= 1'b1;
    end
  end
  assign mem_rdata = tb_wr[mem_addr[7:0]] ? tb_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);

  // Reference model: one transaction record with timestamps, plus a private memory copy.
  bit          m_active;
  int          m_start, m_idx, m_last, m_grant;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_rdata, m_mem_addr, m_mem_wdata;
  bit [31:0]   ref_mem [256];
  bit          ref_wr  [256];

  int          cyc;
  int          vectors, miscompares;
  logic [N-1:0] exp_done;
  logic [N-1:0] s_done, s_stall;
  logic [31:0]  s_rdata;
  logic         s_mem_we;
  logic [IW-1:0] s_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_last      = N - 1;
    m_grant     = 0;
    m_rdata     = '0;
    m_mem_addr  = '0;
    m_mem_wdata = '0;
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : init_val(a[7:0]);
  endfunction

  task automatic set_core(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    req[i]          = r;
    we[i]           = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Check the current cycle against the model, advance the model past the next edge.
  task automatic tick();
    int  rel;
    bit  busy_e, mwe_e;
    @(negedge clk);
    rel      = m_active ? (cyc - m_start) : -1;
    exp_done = (rel == 2) ? (4'b0001 << m_idx) : 4'b0000;
    busy_e   = (rel == 1) || (rel == 2);
    mwe_e    = (rel == 1) && m_we;
    chk("done",      done,      exp_done);
    chk("busy",      busy,      busy_e);
    chk("mem_we",    mem_we,    mwe_e);
    chk("mem_addr",  mem_addr,  m_mem_addr);
    chk("mem_wdata", mem_wdata, m_mem_wdata);
    chk("grant_id",  grant_id,  m_grant);
    chk("rdata",     rdata,     m_rdata);
    chk("stall",     stall,     req & ~exp_done);
    s_done = done; s_stall = stall; s_rdata = rdata; s_mem_we = mem_we; s_grant = grant_id;
    if (!reset) begin
      model_reset();
    end else if (m_active) begin
      if (rel == 1) begin
        if (m_we) begin
          ref_mem[m_addr[7:0]] = m_wdata;
          ref_wr[m_addr[7:0]]  = 1'b1;
        end else begin
          m_rdata = ref_read(m_addr);
        end
      end else if (rel == 2) begin
        m_last   = m_idx;
        m_active = 1'b0;
      end
    end else if (|req) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req[c]) begin
          m_idx       = c;
          m_we        = we[c];
          m_addr      = addr[c*AW +: AW];
          m_wdata     = wdata[c*DW +: DW];
          m_start     = cyc;
          m_active    = 1'b1;
          m_grant     = c;
          m_mem_addr  = m_addr;
          m_mem_wdata = m_wdata;
          break;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    req = '0; we = '0; addr = '0; wdata = '0;
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    cyc   = 0;
  endtask

  bit          pend [N];
  int          wait_c [N];
  int          max_wait;
  int          order [5];
  int          n_ord;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; max_wait = 0;

    // Read from preloaded location by core 2
    start_test();
    set_core(2, 1, 0, 32'h10, 32'h0);
    tick(); chk("t1_stall_c0", s_stall[2], 1);
    tick(); chk("t1_stall_c1", s_stall[2], 1); chk("t1_we_c1", s_mem_we, 0);
    tick(); chk("t1_done", s_done, 4'b0100); chk("t1_rdata", s_rdata, 32'hDEADBEEF);
            chk("t1_stall_c2", s_stall[2], 0);
    set_core(2, 0, 0, 32'h10, 32'h0);
    tick();

    // Write by core 1, read back by core 3
    start_test();
    set_core(1, 1, 1, 32'h20, 32'h12345678);
    tick(); chk("t2_we_c0", s_mem_we, 0);
    tick(); chk("t2_we_c1", s_mem_we, 1);
    tick(); chk("t2_we_c2", s_mem_we, 0); chk("t2_done_w", s_done, 4'b0010);
    set_core(1, 0, 0, 32'h0, 32'h0);
    set_core(3, 1, 0, 32'h20, 32'h0);
    tick(); tick(); tick();
    chk("t2_done_r", s_done, 4'b1000); chk("t2_rdata", s_rdata, 32'h12345678);
    set_core(3, 0, 0, 32'h0, 32'h0);
    tick();

    // All four arrive together from reset
    start_test();
    for (int i = 0; i < N; i++) begin
      set_core(i, 1, 0, 32'(8'h10 + i), 32'h0);
      pend[i] = 1'b1;
    end
    for (int c = 0; c < 13; c++) begin
      tick();
      if (c % 3 == 2 && c < 12) begin
        chk("t3_done_order", s_done, 4'b0001 << (c / 3));
        chk("t3_grant", s_grant, c / 3);
      end
      for (int i = 0; i < N; i++) if (exp_done[i]) set_core(i, 0, 0, 32'h0, 32'h0);
    end

    // Rotation wrap: core 3 first, then cores 0 and 3 competing continuously
    start_test();
    set_core(3, 1, 0, 32'h30, 32'h0);
    n_ord = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c == 0) set_core(0, 1, 0, 32'h31, 32'h0);
      if (c % 3 == 2) begin
        order[n_ord] = (s_done == 4'b0001) ? 0 : (s_done == 4'b1000) ? 3 : -1;
        n_ord++;
      end
    end
    chk("t4_order0", order[0], 3); chk("t4_order1", order[1], 0);
    chk("t4_order2", order[2], 3); chk("t4_order3", order[3], 0);
    chk("t4_order4", order[4], 3);
    req = '0;
    tick();

    // Reset during the memory cycle of a write
    start_test();
    set_core(1, 1, 1, 32'h40, 32'hCAFEF00D);
    tick();
    chk("t5_we_before", mem_we, 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("t5_we_after", mem_we, 0); chk("t5_busy_after", busy, 0); chk("t5_done_after", done, 0);
    tick();
    set_core(0, 1, 0, 32'h40, 32'h0);
    tick();
    reset = 1'b1;
    cyc   = 0;
    tick(); tick(); tick();
    chk("t5_winner", s_done, 4'b0001); chk("t5_nowrite", s_rdata, 32'h40BF1AC3);
    req = '0;
    tick(); tick(); tick(); tick();

    // Address change after latching is ignored
    start_test();
    set_core(0, 1, 0, 32'h10, 32'h0);
    tick();
    set_core(0, 1, 0, 32'h30, 32'h0);
    tick(); tick();
    chk("t6_done", s_done, 4'b0001); chk("t6_rdata", s_rdata, 32'hDEADBEEF);
    req = '0;
    tick();

    // Random traffic
    start_test();
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; wait_c[i] = 0; end
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_core(i, 1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom());
            pend[i] = 1'b1;
          end
        end else if (m_active && m_idx == i && $urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 2))
            0:       req[i] = 1'b0;
            1:       addr[i*AW +: AW] = 32'($urandom_range(0, 63));
            default: begin wdata[i*DW +: DW] = $urandom(); we[i] = ~we[i]; end
          endcase
        end
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (exp_done[i] || !req[i]) wait_c[i] = 0;
        else wait_c[i]++;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
        if (exp_done[i]) begin
          pend[i] = 1'b0;
          req[i]  = 1'b0;
        end
      end
    end
    chk("rand_no_starvation", (max_wait <= 3 * N + 3), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
